// File: rtl/csi_packet_sequencer.sv
// Parses the merged CSI-2 byte stream into packets, emits frame/line strobes and forwards the selected payload with CRC-16 checking.
// Latency: pix/strobe/error outputs are registered, one cycle after the byte that causes them.
// Backpressure: none downstream; byte_valid_i=0 stalls all state, and enable_i=0 aborts to IDLE on the next edge.
module csi_packet_sequencer #(
    parameter logic [7:0]  SYNC_BYTE = 8'hB8,
    parameter logic [15:0] MAX_WC    = 16'd4096
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable_i,
    input  logic [5:0]  cfg_dt_i,
    input  logic [1:0]  cfg_vc_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [7:0]  pix_byte_o,
    output logic        pix_valid_o,
    output logic        pix_last_o,
    output logic        fs_o,
    output logic        fe_o,
    output logic        ls_o,
    output logic        le_o,
    output logic [5:0]  pkt_dt_o,
    output logic [1:0]  pkt_vc_o,
    output logic [15:0] pkt_wc_o,
    output logic        crc_err_o,
    output logic        hdr_err_o,
    output logic [15:0] frame_cnt_o,
    output logic [15:0] line_cnt_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CRC} state_t;

    // CSI-2 CRC-16 (x^16+x^12+x^5+1), reflected form, data folded LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'h8408;
            else             c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [7:0]  di_q, di_d;
    logic [15:0] wc_q, wc_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic        crc_idx_q, crc_idx_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        fwd_q, fwd_d;
    logic [7:0]  pix_byte_q, pix_byte_d;
    logic        pix_valid_q, pix_valid_d;
    logic        pix_last_q, pix_last_d;
    logic        fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
    logic [5:0]  pkt_dt_q, pkt_dt_d;
    logic [1:0]  pkt_vc_q, pkt_vc_d;
    logic [15:0] pkt_wc_q, pkt_wc_d;
    logic        crc_err_q, crc_err_d;
    logic        hdr_err_q, hdr_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] line_cnt_q, line_cnt_d;

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        di_d        = di_q;
        wc_d        = wc_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        crc_idx_d   = crc_idx_q;
        crc_lo_d    = crc_lo_q;
        fwd_d       = fwd_q;
        pix_byte_d  = pix_byte_q;
        pix_valid_d = 1'b0;
        pix_last_d  = 1'b0;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ls_d        = 1'b0;
        le_d        = 1'b0;
        pkt_dt_d    = pkt_dt_q;
        pkt_vc_d    = pkt_vc_q;
        pkt_wc_d    = pkt_wc_q;
        crc_err_d   = 1'b0;
        hdr_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        line_cnt_d  = line_cnt_q;

        if (!enable_i) begin
            state_d = ST_IDLE;
        end else if (byte_valid_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_i == SYNC_BYTE) begin
                        state_d   = ST_HDR;
                        hdr_idx_d = 2'd0;
                    end
                end
                ST_HDR: begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0: di_d       = byte_i;
                        2'd1: wc_d[7:0]  = byte_i;
                        2'd2: wc_d[15:8] = byte_i;
                        default: begin
                            // ECC byte: header complete, decode DI/WC gathered so far.
                            pkt_dt_d = di_q[5:0];
                            pkt_vc_d = di_q[7:6];
                            pkt_wc_d = wc_q;
                            crc_d    = 16'hFFFF;
                            state_d  = ST_IDLE;
                            if (di_q[5:0] < 6'h10) begin
                                if (di_q[7:6] == cfg_vc_i) begin
                                    case (di_q[5:0])
                                        6'h00: begin
                                            fs_d        = 1'b1;
                                            frame_cnt_d = frame_cnt_q + 16'd1;
                                            line_cnt_d  = 16'd0;
                                        end
                                        6'h01:   fe_d = 1'b1;
                                        6'h02:   ls_d = 1'b1;
                                        6'h03:   le_d = 1'b1;
                                        default: ;
                                    endcase
                                end
                            end else if (wc_q > MAX_WC) begin
                                hdr_err_d = 1'b1;
                            end else begin
                                fwd_d     = (di_q[5:0] == cfg_dt_i) && (di_q[7:6] == cfg_vc_i);
                                rem_d     = wc_q;
                                crc_idx_d = 1'b0;
                                state_d   = (wc_q == 16'd0) ? ST_CRC : ST_PAYLOAD;
                            end
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    crc_d = crc16_byte(crc_q, byte_i);
                    rem_d = rem_q - 16'd1;
                    if (fwd_q) begin
                        pix_byte_d  = byte_i;
                        pix_valid_d = 1'b1;
                        pix_last_d  = (rem_q == 16'd1);
                    end
                    if (rem_q == 16'd1) begin
                        state_d   = ST_CRC;
                        crc_idx_d = 1'b0;
                    end
                end
                ST_CRC: begin
                    if (!crc_idx_q) begin
                        crc_lo_d  = byte_i;
                        crc_idx_d = 1'b1;
                    end else begin
                        crc_err_d = ({byte_i, crc_lo_q} != crc_q);
                        if (fwd_q) line_cnt_d = line_cnt_q + 16'd1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            hdr_idx_q   <= 2'd0;
            di_q        <= 8'd0;
            wc_q        <= 16'd0;
            rem_q       <= 16'd0;
            crc_q       <= 16'hFFFF;
            crc_idx_q   <= 1'b0;
            crc_lo_q    <= 8'd0;
            fwd_q       <= 1'b0;
            pix_byte_q  <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
            ls_q        <= 1'b0;
            le_q        <= 1'b0;
            pkt_dt_q    <= 6'd0;
            pkt_vc_q    <= 2'd0;
            pkt_wc_q    <= 16'd0;
            crc_err_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
            line_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            di_q        <= di_d;
            wc_q        <= wc_d;
            rem_q       <= rem_d;
            crc_q       <= crc_d;
            crc_idx_q   <= crc_idx_d;
            crc_lo_q    <= crc_lo_d;
            fwd_q       <= fwd_d;
            pix_byte_q  <= pix_byte_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
            ls_q        <= ls_d;
            le_q        <= le_d;
            pkt_dt_q    <= pkt_dt_d;
            pkt_vc_q    <= pkt_vc_d;
            pkt_wc_q    <= pkt_wc_d;
            crc_err_q   <= crc_err_d;
            hdr_err_q   <= hdr_err_d;
            frame_cnt_q <= frame_cnt_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

    assign pix_byte_o  = pix_byte_q;
    assign pix_valid_o = pix_valid_q;
    assign pix_last_o  = pix_last_q;
    assign fs_o        = fs_q;
    assign fe_o        = fe_q;
    assign ls_o        = ls_q;
    assign le_o        = le_q;
    assign pkt_dt_o    = pkt_dt_q;
    assign pkt_vc_o    = pkt_vc_q;
    assign pkt_wc_o    = pkt_wc_q;
    assign crc_err_o   = crc_err_q;
    assign hdr_err_o   = hdr_err_q;
    assign frame_cnt_o = frame_cnt_q;
    assign line_cnt_o  = line_cnt_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csi_packet_sequencer.sv
// Directed bench for the CSI-2 packet sequencer with hand-computed expectations.
// Payload "123456789" has the well-known CSI-2 CRC-16 value 16'h6F91 (sent 91, 6F).
// A negedge monitor collects forwarded bytes and pulse counts for later comparison.
module tb_csi_packet_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_i;
    logic [5:0]  cfg_dt_i;
    logic [1:0]  cfg_vc_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic [7:0]  pix_byte_o;
    logic        pix_valid_o, pix_last_o;
    logic        fs_o, fe_o, ls_o, le_o;
    logic [5:0]  pkt_dt_o;
    logic [1:0]  pkt_vc_o;
    logic [15:0] pkt_wc_o;
    logic        crc_err_o, hdr_err_o;
    logic [15:0] frame_cnt_o, line_cnt_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csi_packet_sequencer dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .enable_i     (enable_i),
        .cfg_dt_i     (cfg_dt_i),
        .cfg_vc_i     (cfg_vc_i),
        .byte_i       (byte_i),
        .byte_valid_i (byte_valid_i),
        .pix_byte_o   (pix_byte_o),
        .pix_valid_o  (pix_valid_o),
        .pix_last_o   (pix_last_o),
        .fs_o         (fs_o),
        .fe_o         (fe_o),
        .ls_o         (ls_o),
        .le_o         (le_o),
        .pkt_dt_o     (pkt_dt_o),
        .pkt_vc_o     (pkt_vc_o),
        .pkt_wc_o     (pkt_wc_o),
        .crc_err_o    (crc_err_o),
        .hdr_err_o    (hdr_err_o),
        .frame_cnt_o  (frame_cnt_o),
        .line_cnt_o   (line_cnt_o),
        .busy_o       (busy_o)
    );

    // Monitor: only this block writes the collected data.
    logic [7:0] pix_q[$];
    int last_idx = -1;
    int n_last = 0, n_crc = 0, n_hdr = 0, n_fs = 0, n_fe = 0, n_ls = 0, n_le = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (pix_valid_o) begin
                if (pix_last_o) last_idx = pix_q.size();
                pix_q.push_back(pix_byte_o);
            end
            if (pix_last_o) n_last++;
            if (crc_err_o)  n_crc++;
            if (hdr_err_o)  n_hdr++;
            if (fs_o)       n_fs++;
            if (fe_o)       n_fe++;
            if (ls_o)       n_ls++;
            if (le_o)       n_le++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte after an optional stall; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b, input int stall);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            byte_i       = 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
    endtask

    logic [7:0] tx_q[$];

    task automatic send_pkt(input int max_stall);
        foreach (tx_q[i]) send(tx_q[i], (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] good_pl[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    int base, b_last, b_crc, b_hdr, b_ls, b_le, b_fs;

    initial begin
        rst = 1'b1; enable_i = 1'b1; cfg_dt_i = 6'h2B; cfg_vc_i = 2'd0;
        byte_i = 8'h00; byte_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_frame", frame_cnt_o, 0);
        check("rst_line", line_cnt_o, 0);
        check("rst_pix_valid", pix_valid_o, 0);
        check("rst_pkt_wc", pkt_wc_o, 0);
        @(negedge clk); rst = 1'b0;
        idle(2);

        // 1) Frame start.
        tx_q = '{8'hB8, 8'h00, 8'h00, 8'h00, 8'h5A};
        send_pkt(0);
        check("t1_fs", fs_o, 1);
        check("t1_frame", frame_cnt_o, 1);
        check("t1_line", line_cnt_o, 0);
        check("t1_busy", busy_o, 0);
        idle(1);
        check("t1_fs_width", fs_o, 0);

        // 2) Forwarded RAW10 packet, correct CRC.
        base = pix_q.size(); b_last = n_last; b_crc = n_crc;
        tx_q = '{8'hB8, 8'h2B, 8'h09, 8'h00, 8'h00,
                 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
        send_pkt(0);
        idle(2);
        check("t2_count", pix_q.size() - base, 9);
        for (int i = 0; i < 9; i++)
            if (base + i < pix_q.size()) check($sformatf("t2_byte%0d", i), pix_q[base + i], good_pl[i]);
        check("t2_last_pos", last_idx, base + 8);
        check("t2_last_cnt", n_last - b_last, 1);
        check("t2_crc_err", n_crc - b_crc, 0);
        check("t2_line", line_cnt_o, 1);
        check("t2_pkt_dt", pkt_dt_o, 6'h2B);
        check("t2_pkt_wc", pkt_wc_o, 9);

        // FS clears line count before the next line.
        tx_q = '{8'hB8, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        check("fs2_frame", frame_cnt_o, 2);
        check("fs2_line", line_cnt_o, 0);

        // 3) P2 bit0 flipped: still forwarded, CRC error.
        base = pix_q.size(); b_crc = n_crc;
        tx_q = '{8'hB8, 8'h2B, 8'h09, 8'h00, 8'h00,
                 8'h31, 8'h32, 8'h32, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
        send_pkt(0);
        check("t3_crc_pulse", crc_err_o, 1);
        idle(2);
        check("t3_count", pix_q.size() - base, 9);
        check("t3_crc_cnt", n_crc - b_crc, 1);
        check("t3_line", line_cnt_o, 1);

        // 4) Embedded-data packet with SYNC bytes in payload is consumed silently.
        base = pix_q.size();
        tx_q = '{8'hB8, 8'h12, 8'h03, 8'h00, 8'h00, 8'hB8, 8'hB8, 8'hB8, 8'h00, 8'h00};
        send_pkt(0);
        idle(1);
        check("t4_no_pix", pix_q.size() - base, 0);
        check("t4_line", line_cnt_o, 1);
        tx_q = '{8'hB8, 8'h01, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        check("t4_fe", fe_o, 1);
        check("t4_frame", frame_cnt_o, 2);
        b_ls = n_ls; b_le = n_le; b_fs = n_fs;
        tx_q = '{8'hB8, 8'h02, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h03, 8'h34, 8'h12, 8'h00,
                 8'hB8, 8'h42, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h40, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        idle(1);
        check("t4_ls_cnt", n_ls - b_ls, 1);
        check("t4_le_cnt", n_le - b_le, 1);
        check("t4_vc1_fs", n_fs - b_fs, 0);
        check("t4_vc1_frame", frame_cnt_o, 2);
        check("t4_pkt_vc", pkt_vc_o, 1);

        // 5) Oversized word count.
        tx_q = '{8'hB8, 8'h2B, 8'h00, 8'h20, 8'h00};
        send_pkt(0);
        check("t5_hdr_err", hdr_err_o, 1);
        check("t5_busy", busy_o, 0);
        check("t5_pkt_wc", pkt_wc_o, 16'h2000);
        tx_q = '{8'hB8, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(0);
        check("t5_fs_after", fs_o, 1);
        check("t5_frame", frame_cnt_o, 3);
        tx_q = '{8'hB8, 8'h2B, 8'h01, 8'h10, 8'h00};
        send_pkt(0);
        check("t5_wc4097", hdr_err_o, 1);
        tx_q = '{8'hB8, 8'h12, 8'h00, 8'h10, 8'h00};
        send_pkt(0);
        check("t5_wc4096_err", hdr_err_o, 0);
        check("t5_wc4096_busy", busy_o, 1);
        @(negedge clk); enable_i = 1'b0;
        @(posedge clk); #1;
        check("t5_abort_busy", busy_o, 0);
        @(negedge clk); enable_i = 1'b1;
        // Zero-length forwarded packet: CRC stays at seed FFFF.
        base = pix_q.size(); b_crc = n_crc;
        tx_q = '{8'hB8, 8'h2B, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
        send_pkt(0);
        idle(1);
        check("t5_wc0_pix", pix_q.size() - base, 0);
        check("t5_wc0_crc", n_crc - b_crc, 0);
        check("t5_wc0_line", line_cnt_o, 1);

        // 6) Same good packet with random stalls.
        base = pix_q.size(); b_crc = n_crc; b_last = n_last;
        tx_q = '{8'hB8, 8'h2B, 8'h09, 8'h00, 8'h00,
                 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
        send_pkt(3);
        idle(2);
        check("t6_count", pix_q.size() - base, 9);
        for (int i = 0; i < 9; i++)
            if (base + i < pix_q.size()) check($sformatf("t6_byte%0d", i), pix_q[base + i], good_pl[i]);
        check("t6_last", n_last - b_last, 1);
        check("t6_crc", n_crc - b_crc, 0);
        check("t6_line", line_cnt_o, 2);

        // Abort after P1.
        base = pix_q.size(); b_crc = n_crc; b_last = n_last; b_hdr = n_hdr;
        tx_q = '{8'hB8, 8'h2B, 8'h09, 8'h00, 8'h00, 8'h31, 8'h32};
        send_pkt(0);
        @(negedge clk); enable_i = 1'b0; byte_i = 8'h33; byte_valid_i = 1'b1;
        @(posedge clk); #1;
        check("ab_busy", busy_o, 0);
        check("ab_pix_valid", pix_valid_o, 0);
        @(negedge clk); enable_i = 1'b1; byte_valid_i = 1'b0;
        tx_q = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h91, 8'h6F};
        send_pkt(0);
        idle(2);
        check("ab_pix", pix_q.size() - base, 2);
        check("ab_last", n_last - b_last, 0);
        check("ab_crc", n_crc - b_crc, 0);
        check("ab_line", line_cnt_o, 2);

        // Reset in the middle of a header.
        tx_q = '{8'hB8, 8'h2B, 8'h05};
        send_pkt(0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("mr_busy", busy_o, 0);
        check("mr_frame", frame_cnt_o, 0);
        check("mr_line", line_cnt_o, 0);
        check("mr_pkt_dt", pkt_dt_o, 0);
        @(negedge clk); rst = 1'b0;
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
